mux4_reg: RTL and testbench
===========================

Name: mux4_reg

Overview:
- Registered, parameterized 4-to-1 multiplexer.
- One of four WIDTH-bit data inputs (a, b, c, d) is selected by a 2-bit select split across sel1 (MSB) and sel2 (LSB).
- The selection is available combinationally and also as a registered output with a valid flag.
- Used as a generic datapath steering element wherever one of four sources feeds a single sink.

Parameters:
- WIDTH, 1, bit width of each data input and of both outputs (minimum 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- a  input  WIDTH  data source 0.
- b  input  WIDTH  data source 1.
- c  input  WIDTH  data source 2.
- d  input  WIDTH  data source 3.
- sel1  input  1  select MSB.
- sel2  input  1  select LSB.
- in_valid  input  1  capture strobe for the registered path.
- y_comb  output  WIDTH  combinational mux result.
- y  output  WIDTH  registered mux result.
- out_valid  output  1  y holds a value captured on the previous in_valid cycle.
- sel_q  output  2  select value {sel1,sel2} latched with y.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. No other clock or reset.
- Select mapping, using {sel1,sel2}:
  - 2'b00 -> a
  - 2'b01 -> b
  - 2'b10 -> c
  - 2'b11 -> d
- y_comb:
  - Purely combinational; updates in the same delta as any input change. No clock involvement.
  - Unaffected by rst.
  - Fully decoded (no latch): every select code drives a defined source.
  - If sel1 or sel2 is X/Z in simulation, y_comb is X.
- Registered path, on each rising clk edge:
  - rst=1: y <= 0, sel_q <= 2'b00, out_valid <= 0. rst has priority over in_valid.
  - rst=0, in_valid=1: y <= y_comb value, sel_q <= {sel1,sel2}, out_valid <= 1.
  - rst=0, in_valid=0: y and sel_q hold their values; out_valid <= 0.
- Latency: y_comb is 0 cycles; y/out_valid is exactly 1 cycle after the in_valid edge.
- Back-to-back in_valid: a new value is captured every cycle with no bubbles; out_valid stays 1.
- No backpressure: the sink must consume y while out_valid=1.
- Reset mid-stream: a capture in the same cycle as rst is discarded, and out_valid is 0 on the following cycle.
- Data inputs that change while in_valid=0 have no effect on y.
- Width rule: every output bit comes from the same-index bit of the selected source. No sign or zero extension.
- Reset values: y=0, sel_q=0, out_valid=0. y_comb has no reset value (it is combinational).

Decomposition:
- Shared package mux4_pkg holds:
  - typedef sel_t as a 2-bit enum: SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11.
  - A function that packs sel1/sel2 into sel_t.
- Sub-module mux4_core: a purely combinational WIDTH-bit 4:1 selector (inputs a..d and sel_t, output y).
- mux4_reg instantiates mux4_core for y_comb and adds the capture register, valid flag and sel_q.

Test Plan:
- One-hot walk, WIDTH=1, in_valid=1:
  - a=1,b=0,c=0,d=0, sel=00 -> y_comb=1.
  - a=0,b=1,c=0,d=0, sel=01 -> y_comb=1.
  - a=0,b=0,c=1,d=0, sel=10 -> y_comb=1.
  - a=0,b=0,c=0,d=1, sel=11 -> y_comb=1.
  - For each vector, y=1 and sel_q equals that vector's select code on the next edge.
- Isolation, WIDTH=8: a=8'h11, b=8'h22, c=8'h33, d=8'h44; sweep sel 00..11 -> y_comb is 11,22,33,44. Toggling any unselected input leaves y_comb unchanged.
- Latency/valid: pulse in_valid for one cycle with sel=10, c=8'hA5 -> the next edge gives y=A5, out_valid=1, sel_q=2'b10. The following edge gives out_valid=0 and y still A5.
- Hold: in_valid=0 while a..d and sel change randomly for 10 cycles -> y and sel_q constant, out_valid=0.
- Reset priority: rst=1 and in_valid=1 with sel=11, d=8'hFF -> after the edge, y=0, sel_q=00, out_valid=0. y_comb still shows FF.
- Streaming: in_valid held at 1 for 4 cycles with sel cycling 00,01,10,11 -> y follows a,b,c,d one cycle late with out_valid continuously 1.

Source files
------------

// File: rtl/mux4_pkg.sv
// mux4_pkg: shared types for the registered 4:1 mux.
//   sel_t    - 2-bit source select, {sel1,sel2} -> a/b/c/d
//   pack_sel - packs the split select pins into sel_t
package mux4_pkg;

  typedef enum logic [1:0] {
    SEL_A = 2'b00,
    SEL_B = 2'b01,
    SEL_C = 2'b10,
    SEL_D = 2'b11
  } sel_t;

  // sel1 is the MSB. An X/Z pin stays X through the cast so the selector
  // can propagate it to its output.
  function automatic sel_t pack_sel(input logic sel1, input logic sel2);
    return sel_t'({sel1, sel2});
  endfunction

endpackage

// File: rtl/mux4_core.sv
// mux4_core: purely combinational WIDTH-bit 4:1 selector.
//   a..d - data sources 0..3
//   sel  - source select
//   y    - selected source, bit-for-bit
module mux4_core
  import mux4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    // All four codes are decoded; the default only fires on an X/Z select
    // in simulation, where the result is meant to be X.
    y = {WIDTH{1'bx}};
    case (sel)
      SEL_A:   y = a;
      SEL_B:   y = b;
      SEL_C:   y = c;
      SEL_D:   y = d;
      default: y = {WIDTH{1'bx}};
    endcase
  end

endmodule

// File: rtl/mux4_reg.sv
// mux4_reg: registered, parameterized 4:1 mux with valid flag.
//   clk, rst  - rising-edge clock, synchronous active-high reset
//   a..d      - data sources 0..3 (WIDTH bits)
//   sel1/sel2 - select MSB/LSB
//   in_valid  - capture strobe for the registered path
//   y_comb    - combinational mux result (not reset)
//   y         - mux result captured on the last in_valid cycle
//   out_valid - y was captured on the previous cycle
//   sel_q     - select code captured together with y
module mux4_reg
  import mux4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             sel1,
  input  logic             sel2,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y_comb,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic [1:0]       sel_q
);

  sel_t sel_in;
  assign sel_in = pack_sel(sel1, sel2);

  mux4_core #(.WIDTH(WIDTH)) u_core (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (sel_in),
    .y   (y_comb)
  );

  logic [WIDTH-1:0] y_d, y_q;
  logic [1:0]       sel_d;
  logic             out_valid_d, out_valid_q;

  // Data and select hold when idle; valid is a one-cycle pulse per capture.
  always_comb begin
    y_d         = y_q;
    sel_d       = sel_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      y_d   = y_comb;
      sel_d = sel_in;
    end
  end

  // Reset wins over a same-cycle capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q         <= '0;
      sel_q       <= 2'b00;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux4_reg.sv
// tb_mux4_reg: directed + random checks of mux4_reg at WIDTH=8 and WIDTH=1
// against a behavioural model (indexed source array plus a capture register).
module tb_mux4_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, sel1, sel2, in_valid;
  logic [7:0] a8, b8, c8, d8;
  logic       a1, b1, c1, d1;

  logic [7:0] yc8, y8;
  logic       ov8;
  logic [1:0] sq8;
  logic       yc1, y1, ov1;
  logic [1:0] sq1;

  mux4_reg #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .d(d8),
    .sel1(sel1), .sel2(sel2), .in_valid(in_valid),
    .y_comb(yc8), .y(y8), .out_valid(ov8), .sel_q(sq8)
  );

  mux4_reg #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .d(d1),
    .sel1(sel1), .sel2(sel2), .in_valid(in_valid),
    .y_comb(yc1), .y(y1), .out_valid(ov1), .sel_q(sq1)
  );

  // Reference model state
  logic [7:0] m_y8;
  logic       m_y1;
  logic [1:0] m_sel;
  logic       m_vld;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [7:0] ref8();
    logic [7:0] src [4];
    src = '{a8, b8, c8, d8};
    return src[{sel1, sel2}];
  endfunction

  function automatic logic ref1();
    logic src [4];
    src = '{a1, b1, c1, d1};
    return src[{sel1, sel2}];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_comb();
    #1;
    chk("y_comb8", yc8, ref8());
    chk("y_comb1", {7'b0, yc1}, {7'b0, ref1()});
  endtask

  // Check the combinational path, advance one edge, update the model from
  // the inputs seen at that edge, then check the registered outputs.
  task automatic cycle();
    logic [7:0] nx8;
    logic       nx1;
    logic [1:0] nsel;
    check_comb();
    nx8  = ref8();
    nx1  = ref1();
    nsel = {sel1, sel2};
    @(posedge clk);
    if (rst) begin
      m_y8 = 8'h00; m_y1 = 1'b0; m_sel = 2'b00; m_vld = 1'b0;
    end else begin
      m_vld = in_valid;
      if (in_valid) begin
        m_y8 = nx8; m_y1 = nx1; m_sel = nsel;
      end
    end
    #1;
    chk("y8",         y8,              m_y8);
    chk("sel_q8",     {6'b0, sq8},     {6'b0, m_sel});
    chk("out_valid8", {7'b0, ov8},     {7'b0, m_vld});
    chk("y1",         {7'b0, y1},      {7'b0, m_y1});
    chk("sel_q1",     {6'b0, sq1},     {6'b0, m_sel});
    chk("out_valid1", {7'b0, ov1},     {7'b0, m_vld});
  endtask

  task automatic rand_data();
    a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom); d8 = 8'($urandom);
    {a1, b1, c1, d1} = 4'($urandom);
  endtask

  task automatic set_sel(input logic [1:0] s);
    {sel1, sel2} = s;
  endtask

  initial begin
    m_y8 = '0; m_y1 = 1'b0; m_sel = '0; m_vld = 1'b0;
    rst = 1'b1; in_valid = 1'b0; sel1 = 1'b0; sel2 = 1'b0;
    rand_data();

    // Reset state
    cycle();
    cycle();
    chk("rst_y8", y8, 8'h00);
    chk("rst_ov8", {7'b0, ov8}, 8'h00);
    rst = 1'b0;

    // One-hot walk: the selected 1-bit source is the only one set
    for (int s = 0; s < 4; s++) begin
      logic [3:0] oh;
      oh = 4'b1000 >> s;
      {a1, b1, c1, d1} = oh;
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom); d8 = 8'($urandom);
      set_sel(2'(s));
      in_valid = 1'b1;
      #1 chk("onehot_ycomb", {7'b0, yc1}, 8'h01);
      cycle();
      chk("onehot_y", {7'b0, y1}, 8'h01);
      chk("onehot_selq", {6'b0, sq1}, 8'(s));
    end
    in_valid = 1'b0;
    cycle();

    // Isolation: unselected inputs never reach y_comb
    a8 = 8'h11; b8 = 8'h22; c8 = 8'h33; d8 = 8'h44;
    for (int s = 0; s < 4; s++) begin
      logic [7:0] want;
      want = 8'h11 * 8'(s + 1);
      set_sel(2'(s));
      #1 chk("iso_sweep", yc8, want);
      for (int t = 0; t < 4; t++) begin
        if (t != s) begin
          case (t)
            0: a8 = ~a8;
            1: b8 = ~b8;
            2: c8 = ~c8;
            default: d8 = ~d8;
          endcase
          #1 chk("iso_toggle", yc8, want);
          case (t)
            0: a8 = ~a8;
            1: b8 = ~b8;
            2: c8 = ~c8;
            default: d8 = ~d8;
          endcase
        end
      end
    end

    // Latency: single in_valid pulse
    set_sel(2'b10); c8 = 8'hA5; in_valid = 1'b1;
    cycle();
    chk("lat_y", y8, 8'hA5);
    chk("lat_ov", {7'b0, ov8}, 8'h01);
    chk("lat_selq", {6'b0, sq8}, 8'h02);
    in_valid = 1'b0;
    cycle();
    chk("lat_ov_drop", {7'b0, ov8}, 8'h00);
    chk("lat_y_hold", y8, 8'hA5);

    // Hold: idle inputs churn, registered outputs stay put
    for (int i = 0; i < 10; i++) begin
      rand_data();
      set_sel(2'($urandom));
      cycle();
      chk("hold_y", y8, 8'hA5);
      chk("hold_selq", {6'b0, sq8}, 8'h02);
    end

    // Reset priority over a same-cycle capture
    rst = 1'b1; in_valid = 1'b1; set_sel(2'b11); d8 = 8'hFF;
    cycle();
    chk("rstpri_y", y8, 8'h00);
    chk("rstpri_selq", {6'b0, sq8}, 8'h00);
    chk("rstpri_ov", {7'b0, ov8}, 8'h00);
    chk("rstpri_ycomb", yc8, 8'hFF);
    rst = 1'b0; in_valid = 1'b0;

    // Streaming: back-to-back captures, no bubbles
    in_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      rand_data();
      set_sel(2'(s));
      cycle();
      chk("stream_ov", {7'b0, ov8}, 8'h01);
    end
    in_valid = 1'b0;
    cycle();

    // Random traffic with occasional resets
    for (int i = 0; i < 60; i++) begin
      rand_data();
      set_sel(2'($urandom));
      in_valid = 1'($urandom);
      rst = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
